bsg_down_read_ctrl: RTL and testbench

Core-side read sequencer for the downstream off-chip channel buffer. The write side packs received io bytes into 16-bit entries of a 64-entry buffer and advances a 7-bit write pointer. This block drains pairs of entries into 32-bit core words with a valid/ready handshake, advances the read pointer, and returns credits to the io side as decimated token pulses. It owns the buffer's read port, `rptr`, and the full/empty status.

---
 rtl/bsg_down_pkg.sv | 9 +
 rtl/bsg_down_credit_ctr.sv | 26 ++
 rtl/bsg_down_read_ctrl.sv | 97 +++++++++
 tb/tb_bsg_down_read_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_down_pkg.sv
// bsg_down_pkg: shared state encoding, default widths and pointer occupancy helper
package bsg_down_pkg;
   localparam int ADDR_W_DEF = 6;
   localparam int ENTRY_W_DEF = 16;
   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, LATCH_HI, VALID} state_t;
   function automatic logic [31:0] occ_f(input logic [31:0] w, input logic [31:0] r, input int aw);
      return (w - r) & ((32'd1 << (aw + 1)) - 32'd1);
   endfunction
endpackage

// File: rtl/bsg_down_credit_ctr.sv
// bsg_down_credit_ctr: folds freed entry pairs into decimated io credit pulses
module bsg_down_credit_ctr
   import bsg_down_pkg::*;
#(
   parameter int TOKEN_DECIMATION = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic free2,
   output logic io_token_out
);
   localparam int CW = $clog2(TOKEN_DECIMATION) + 1;
   logic [CW-1:0] tok_cnt, sum;
   logic hit;
   assign sum = tok_cnt + CW'(2);
   assign hit = sum >= CW'(TOKEN_DECIMATION);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_cnt <= '0;
         io_token_out <= 1'b0;
      end else begin
         io_token_out <= free2 && hit;
         if (free2) tok_cnt <= hit ? sum - CW'(TOKEN_DECIMATION) : sum;
      end
   end
endmodule

// File: rtl/bsg_down_read_ctrl.sv
// bsg_down_read_ctrl: drains 16-bit entry pairs into 32-bit core words and returns io credits
module bsg_down_read_ctrl
   import bsg_down_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ENTRY_W = ENTRY_W_DEF,
   parameter int TOKEN_DECIMATION = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_W:0]      wptr,
   output logic [ADDR_W-1:0]    buffer_raddr,
   input  logic [ENTRY_W-1:0]   buffer_rdata,
   output logic [2*ENTRY_W-1:0] core_data_out,
   output logic                 core_valid_out,
   input  logic                 core_ready,
   output logic [ADDR_W:0]      rptr,
   output logic                 full,
   output logic                 empty,
   output logic                 io_token_out,
   output logic                 ovf_err
);
   localparam int PW = ADDR_W + 1;
   state_t state, state_n;
   logic [PW-1:0] rptr_n, rptr_a1, rptr_a2;
   logic [ADDR_W-1:0] raddr_n;
   logic [ENTRY_W-1:0] lo, hi, lo_n, hi_n;
   logic [31:0] occ, occ_a2;
   logic free2;
   assign rptr_a1 = rptr + PW'(1);
   assign rptr_a2 = rptr + PW'(2);
   assign occ = occ_f(32'(wptr), 32'(rptr), ADDR_W);
   assign occ_a2 = occ_f(32'(wptr), 32'(rptr_a2), ADDR_W);
   assign empty = wptr == rptr;
   assign full = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
   assign core_valid_out = state == VALID;
   assign core_data_out = {hi, lo};
   // raddr is registered so the synchronous buffer returns lo in RD_HI and hi in LATCH_HI
   always_comb begin
      state_n = state;
      rptr_n = rptr;
      raddr_n = buffer_raddr;
      lo_n = lo;
      hi_n = hi;
      free2 = 1'b0;
      case (state)
         IDLE: begin
            state_n = occ >= 32'd2 ? RD_LO : IDLE;
            raddr_n = occ >= 32'd2 ? rptr[ADDR_W-1:0] : buffer_raddr;
         end
         RD_LO: begin
            state_n = RD_HI;
            raddr_n = rptr_a1[ADDR_W-1:0];
         end
         RD_HI: begin
            state_n = LATCH_HI;
            lo_n = buffer_rdata;
         end
         LATCH_HI: begin
            state_n = VALID;
            hi_n = buffer_rdata;
         end
         VALID: begin
            if (core_ready) begin
               free2 = 1'b1;
               rptr_n = rptr_a2;
               state_n = occ_a2 >= 32'd2 ? RD_LO : IDLE;
               raddr_n = occ_a2 >= 32'd2 ? rptr_a2[ADDR_W-1:0] : buffer_raddr;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rptr <= '0;
         buffer_raddr <= '0;
         lo <= '0;
         hi <= '0;
         ovf_err <= 1'b0;
      end else begin
         state <= state_n;
         rptr <= rptr_n;
         buffer_raddr <= raddr_n;
         lo <= lo_n;
         hi <= hi_n;
         ovf_err <= ovf_err | (occ > (32'd1 << ADDR_W));
      end
   end
   bsg_down_credit_ctr #(.TOKEN_DECIMATION(TOKEN_DECIMATION)) u_credit (
      .clk(clk),
      .rst_n(rst_n),
      .free2(free2),
      .io_token_out(io_token_out)
   );
endmodule

// File: tb/tb_bsg_down_read_ctrl.sv
// tb_bsg_down_read_ctrl: directed checks of the downstream read sequencer
module tb_bsg_down_read_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [6:0] wptr = '0;
   logic [5:0] buffer_raddr;
   logic [15:0] buffer_rdata;
   logic [31:0] core_data_out;
   logic core_valid_out;
   logic core_ready = 1'b0;
   logic [6:0] rptr;
   logic full, empty, io_token_out, ovf_err;
   logic [15:0] mem [64];
   logic [6:0] rp;
   int checks = 0;
   int errors = 0;

   bsg_down_read_ctrl #(.ADDR_W(6), .ENTRY_W(16), .TOKEN_DECIMATION(4)) dut (
      .clk(clk), .rst_n(rst_n), .wptr(wptr), .buffer_raddr(buffer_raddr),
      .buffer_rdata(buffer_rdata), .core_data_out(core_data_out),
      .core_valid_out(core_valid_out), .core_ready(core_ready), .rptr(rptr),
      .full(full), .empty(empty), .io_token_out(io_token_out), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) buffer_rdata <= mem[buffer_raddr];

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wptr = '0;
      core_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rp = '0;
   endtask

   // streams n words with core_ready high; checks data, spacing, final rptr; returns token stats
   task automatic stream(input int n, input bit chk_tp, output int tok_hi, output int tok_rise);
      int got, cyc, last;
      logic prev_tok;
      logic [5:0] a, b;
      logic [31:0] exp;
      got = 0; cyc = 0; last = -1; tok_hi = 0; tok_rise = 0; prev_tok = 1'b0;
      @(negedge clk);
      wptr = rp + 7'(2 * n);
      core_ready = 1'b1;
      while (got < n && cyc < 8 * n + 20) begin
         @(negedge clk);
         cyc++;
         if (io_token_out) tok_hi++;
         if (io_token_out && !prev_tok) tok_rise++;
         prev_tok = io_token_out;
         if (core_valid_out) begin
            a = rp[5:0];
            b = a + 6'd1;
            exp = {mem[b], mem[a]};
            checks++;
            if (core_data_out !== exp) begin
               errors++;
               $display("FAIL stream_data rp=%h got %h exp %h", rp, core_data_out, exp);
            end
            if (chk_tp && last >= 0) begin
               checks++;
               if (cyc - last != 4) begin
                  errors++;
                  $display("FAIL throughput got %0d cycles exp 4", cyc - last);
               end
            end
            last = cyc;
            got++;
            rp = rp + 7'd2;
         end
      end
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL stream_timeout got %0d words exp %0d", got, n);
      end
      repeat (2) begin
         @(negedge clk);
         core_ready = 1'b0;
         if (io_token_out) tok_hi++;
         if (io_token_out && !prev_tok) tok_rise++;
         prev_tok = io_token_out;
      end
      checks++;
      if (rptr !== rp) begin
         errors++;
         $display("FAIL stream_rptr got %h exp %h", rptr, rp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (core_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", core_valid_out); end
      checks++; if (core_data_out !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", core_data_out); end
      checks++; if (rptr !== 7'h0) begin errors++; $display("FAIL rst_rptr got %h exp 0", rptr); end
      checks++; if (buffer_raddr !== 6'h0) begin errors++; $display("FAIL rst_raddr got %h exp 0", buffer_raddr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
      checks++; if (io_token_out !== 1'b0) begin errors++; $display("FAIL rst_token got %b exp 0", io_token_out); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf_err); end
   endtask

   task automatic test_basic_stall();
      bit bad;
      @(negedge clk);
      wptr = 7'd2;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (core_valid_out !== 1'b0) begin errors++; $display("FAIL basic_early got %b exp 0", core_valid_out); end
      @(posedge clk);
      #1;
      checks++; if (core_valid_out !== 1'b1) begin errors++; $display("FAIL basic_latency got %b exp 1", core_valid_out); end
      checks++; if (core_data_out !== 32'h78563412) begin errors++; $display("FAIL basic_data got %h exp 78563412", core_data_out); end
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (core_valid_out !== 1'b1 || core_data_out !== 32'h78563412 || rptr !== 7'h0) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL stall_hold got valid %b data %h rptr %h exp 1 78563412 00", core_valid_out, core_data_out, rptr); end
      core_ready = 1'b1;
      @(posedge clk);
      #1;
      core_ready = 1'b0;
      checks++; if (rptr !== 7'd2) begin errors++; $display("FAIL basic_rptr got %h exp 02", rptr); end
      repeat (6) @(negedge clk);
      checks++; if (rptr !== 7'd2) begin errors++; $display("FAIL stall_one_advance got %h exp 02", rptr); end
      checks++; if (core_valid_out !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %b exp 0", core_valid_out); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", empty); end
      rp = 7'd2;
   endtask

   task automatic test_tokens();
      int hi, rise;
      do_reset();
      stream(4, 1'b1, hi, rise);
      checks++; if (rise != 2) begin errors++; $display("FAIL token_pulses got %0d exp 2", rise); end
      checks++; if (hi != 2) begin errors++; $display("FAIL token_width got %0d high cycles exp 2", hi); end
   endtask

   task automatic test_wrap();
      int hi, rise;
      stream(29, 1'b0, hi, rise);
      stream(30, 1'b0, hi, rise);
      checks++; if (rptr !== 7'h7E) begin errors++; $display("FAIL wrap_start got %h exp 7e", rptr); end
      stream(2, 1'b0, hi, rise);
      checks++; if (rptr !== 7'h02) begin errors++; $display("FAIL wrap_end got %h exp 02", rptr); end
   endtask

   task automatic test_full();
      int n;
      @(negedge clk);
      wptr = 7'd66;
      #1;
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set got %b exp 1", full); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", empty); end
      @(posedge clk);
      #1;
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b exp 0", ovf_err); end
      n = 0;
      while (core_valid_out !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++; if (core_valid_out !== 1'b1) begin errors++; $display("FAIL full_wait_valid got %b exp 1", core_valid_out); end
      @(negedge clk);
      core_ready = 1'b1;
      @(posedge clk);
      #1;
      core_ready = 1'b0;
      checks++; if (rptr !== 7'd4) begin errors++; $display("FAIL full_rptr got %h exp 04", rptr); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear got %b exp 0", full); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      #1;
      checks++; if (buffer_raddr !== 6'd5) begin errors++; $display("FAIL mid_rd_hi_raddr got %h exp 05", buffer_raddr); end
      rst_n = 1'b0;
      wptr = 7'd1;
      #1;
      checks++; if (core_data_out !== 32'h0) begin errors++; $display("FAIL mid_data got %h exp 0", core_data_out); end
      checks++; if (rptr !== 7'h0) begin errors++; $display("FAIL mid_rptr got %h exp 0", rptr); end
      checks++; if (buffer_raddr !== 6'h0) begin errors++; $display("FAIL mid_raddr got %h exp 0", buffer_raddr); end
      checks++; if (core_valid_out !== 1'b0 || io_token_out !== 1'b0) begin errors++; $display("FAIL mid_valid_token got %b%b exp 00", core_valid_out, io_token_out); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++; if (core_valid_out !== 1'b0 || rptr !== 7'h0 || buffer_raddr !== 6'h0) begin errors++; $display("FAIL single_entry_idle got valid %b rptr %h raddr %h exp 0 00 00", core_valid_out, rptr, buffer_raddr); end
      checks++; if (io_token_out !== 1'b0) begin errors++; $display("FAIL mid_no_token got %b exp 0", io_token_out); end
      wptr = 7'd65;
      @(negedge clk);
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_err); end
      wptr = 7'd1;
      repeat (6) @(negedge clk);
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_err); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'(i * 259 + 16'h5A00);
      mem[0] = 16'h3412;
      mem[1] = 16'h7856;
      rp = '0;
      test_reset();
      test_basic_stall();
      test_tokens();
      test_wrap();
      test_full();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
